channel_ctrl: RTL and testbench

- Two-channel up/down command dispatcher.
- A request strobe samples the channel select (Ch1/Ch2) and direction (Up/Down) levels, then drives exactly one of four registered command outputs for a fixed pulse width.
- Sits between front-panel/level inputs and the per-channel up/down actuators (e.g. channel gain or position steppers).
- All inputs are asynchronous to clk and are synchronised internally.

---
 rtl/channel_ctrl.sv | 78 +++++++
 tb/tb_channel_ctrl.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/channel_ctrl.sv
// channel_ctrl: two-channel up/down command dispatcher. A synchronised request edge issues one fixed-width pulse on one of four outputs.
module channel_ctrl #(
  parameter int PULSE_CYCLES = 16,
  parameter int SYNC_STAGES  = 2
) (
  input  logic clk,
  input  logic Reset,
  input  logic Ch1,
  input  logic Ch2,
  input  logic request,
  input  logic Up,
  input  logic Down,
  output logic Ch1_up,
  output logic Ch2_up,
  output logic Ch2_down,
  output logic Ch1_down
);
  localparam int CW = $clog2(PULSE_CYCLES + 1);
  localparam int SW = $clog2(SYNC_STAGES + 1);
  typedef enum logic [1:0] {IDLE, ACTIVE, HOLD} state_t;
  state_t state_q, state_d;
  logic [SYNC_STAGES-1:0][4:0] sync_q;
  logic [SW-1:0] settle_q;
  logic req_d_q, settled, req_edge, valid;
  logic ch1_s, ch2_s, up_s, down_s, req_s;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0] cmd_q, cmd_d, cmd_dec, out_q, out_d;
  assign {req_s, down_s, up_s, ch2_s, ch1_s} = sync_q[SYNC_STAGES-1];
  assign settled  = settle_q == SW'(SYNC_STAGES);
  assign req_edge = req_s & ~req_d_q;
  assign valid    = (ch1_s ^ ch2_s) & (up_s ^ down_s);
  assign cmd_dec  = {ch2_s & down_s, ch2_s & up_s, ch1_s & down_s, ch1_s & up_s};
  // Until the chain has refilled after reset, the edge flop is held high so a request held across release is not seen as a new edge.
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      sync_q   <= '0;
      settle_q <= '0;
      req_d_q  <= 1'b0;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], {request, Down, Up, Ch2, Ch1}};
      settle_q <= settled ? settle_q : settle_q + 1'b1;
      req_d_q  <= settled ? req_s : 1'b1;
    end
  end
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      cmd_q   <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cmd_q   <= cmd_d;
      out_q   <= out_d;
    end
  end
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cmd_d   = cmd_q;
    case (state_q)
      IDLE: if (req_edge && valid) begin
        state_d = ACTIVE;
        cnt_d   = CW'(PULSE_CYCLES);
        cmd_d   = cmd_dec;
      end
      ACTIVE: begin
        state_d = (cnt_q == CW'(1)) ? HOLD : ACTIVE;
        cnt_d   = cnt_q - 1'b1;
      end
      HOLD:    state_d = req_s ? HOLD : IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_comb out_d = (state_q == ACTIVE) ? cmd_q : 4'b0;
  assign {Ch2_down, Ch2_up, Ch1_down, Ch1_up} = out_q;
endmodule

// File: tb/tb_channel_ctrl.sv
// tb_channel_ctrl: directed tests of channel_ctrl pulse decode, width, latency, lockout and reset.
module tb_channel_ctrl;
  logic clk = 1'b0, Reset = 1'b1;
  logic Ch1 = 0, Ch2 = 0, request = 0, Up = 0, Down = 0;
  logic Ch1_up, Ch2_up, Ch2_down, Ch1_down;
  logic [3:0] outs;
  int errors = 0, checks = 0;
  int hc[4], fc[4], multi;
  channel_ctrl #(.PULSE_CYCLES(16), .SYNC_STAGES(2)) dut (
    .clk(clk), .Reset(Reset), .Ch1(Ch1), .Ch2(Ch2), .request(request), .Up(Up), .Down(Down),
    .Ch1_up(Ch1_up), .Ch2_up(Ch2_up), .Ch2_down(Ch2_down), .Ch1_down(Ch1_down)
  );
  assign outs = {Ch2_down, Ch2_up, Ch1_down, Ch1_up};
  always #5 clk = ~clk;
  task automatic clear_stats();
    for (int i = 0; i < 4; i++) begin hc[i] = 0; fc[i] = 0; end
    multi = 0;
  endtask
  task automatic sample(input int k);
    for (int i = 0; i < 4; i++) if (outs[i]) begin hc[i]++; if (fc[i] == 0) fc[i] = k; end
    if ($countones(outs) > 1) multi++;
  endtask
  task automatic set_sel(input logic c1, input logic c2, input logic u, input logic d);
    Ch1 = c1; Ch2 = c2; Up = u; Down = d;
  endtask
  task automatic run(input int req_len, input int n);
    clear_stats();
    @(posedge clk); #1 request = 1;
    for (int k = 1; k <= n; k++) begin
      @(posedge clk); #1;
      if (k == req_len) request = 0;
      sample(k);
    end
  endtask
  task automatic test_reset();
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1 request = ~request;
      checks++;
      if (outs !== 4'b0) begin errors++; $display("FAIL reset_hold: outs=%b expected 0000", outs); end
    end
    request = 1;
    @(posedge clk); #1 Reset = 0;
    clear_stats();
    for (int k = 1; k <= 30; k++) begin @(posedge clk); #1 sample(k); end
    checks++;
    if (hc[0] + hc[1] + hc[2] + hc[3] !== 0) begin
      errors++; $display("FAIL reset_release_held_req: high cycles=%0d expected 0", hc[0] + hc[1] + hc[2] + hc[3]);
    end
    request = 0;
    repeat (5) @(posedge clk);
  endtask
  task automatic test_cmd(input logic c1, input logic c2, input logic u, input logic d, input int idx);
    set_sel(c1, c2, u, d);
    run(5, 30);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (hc[i] !== ((i == idx) ? 16 : 0)) begin
        errors++; $display("FAIL cmd%0d_width_out%0d: got %0d expected %0d", idx, i, hc[i], (i == idx) ? 16 : 0);
      end
    end
    checks++;
    if (fc[idx] !== 4) begin errors++; $display("FAIL cmd%0d_latency: got %0d expected 4", idx, fc[idx]); end
  endtask
  task automatic test_invalid();
    set_sel(1, 1, 1, 0);
    run(5, 30);
    checks++;
    if (hc[0] + hc[1] + hc[2] + hc[3] !== 0) begin errors++; $display("FAIL invalid_both_ch: high cycles=%0d expected 0", hc[0] + hc[1] + hc[2] + hc[3]); end
    set_sel(1, 0, 1, 1);
    run(5, 30);
    checks++;
    if (hc[0] + hc[1] + hc[2] + hc[3] !== 0) begin errors++; $display("FAIL invalid_both_dir: high cycles=%0d expected 0", hc[0] + hc[1] + hc[2] + hc[3]); end
    set_sel(0, 0, 0, 1);
    run(5, 30);
    checks++;
    if (hc[0] + hc[1] + hc[2] + hc[3] !== 0) begin errors++; $display("FAIL invalid_no_ch: high cycles=%0d expected 0", hc[0] + hc[1] + hc[2] + hc[3]); end
  endtask
  task automatic test_held_request();
    set_sel(1, 0, 1, 0);
    clear_stats();
    @(posedge clk); #1 request = 1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (k == 8) set_sel(0, 1, 0, 1);
      sample(k);
    end
    checks++;
    if (hc[0] !== 16) begin errors++; $display("FAIL held_ch1_up_width: got %0d expected 16", hc[0]); end
    checks++;
    if (hc[3] !== 0) begin errors++; $display("FAIL held_no_second: ch2_down cycles=%0d expected 0", hc[3]); end
    request = 0;
    repeat (5) @(posedge clk);
    run(5, 30);
    checks++;
    if (hc[3] !== 16) begin errors++; $display("FAIL held_rearm_ch2_down: got %0d expected 16", hc[3]); end
  endtask
  task automatic test_back_to_back();
    set_sel(1, 0, 1, 0);
    clear_stats();
    @(posedge clk); #1 request = 1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (k == 3) request = 0;
      if (k == 8) begin set_sel(0, 1, 0, 1); request = 1; end
      if (k == 10) request = 0;
      sample(k);
    end
    checks++;
    if (hc[0] !== 16) begin errors++; $display("FAIL b2b_ch1_up_width: got %0d expected 16", hc[0]); end
    checks++;
    if (hc[3] !== 0) begin errors++; $display("FAIL b2b_not_queued: ch2_down cycles=%0d expected 0", hc[3]); end
    checks++;
    if (multi !== 0) begin errors++; $display("FAIL b2b_onehot: multi-high cycles=%0d expected 0", multi); end
  endtask
  task automatic test_reset_mid_pulse();
    logic seen;
    set_sel(1, 0, 1, 0);
    @(posedge clk); #1 request = 1;
    for (int k = 1; k <= 11; k++) begin
      @(posedge clk); #1;
      if (k == 5) request = 0;
    end
    seen = Ch1_up;
    checks++;
    if (seen !== 1'b1) begin errors++; $display("FAIL mid_pulse_active: ch1_up=%b expected 1", seen); end
    Reset = 1;
    #1;
    checks++;
    if (Ch1_up !== 1'b0) begin errors++; $display("FAIL mid_pulse_async_clear: ch1_up=%b expected 0", Ch1_up); end
    repeat (2) @(posedge clk);
    #1 Reset = 0;
    clear_stats();
    for (int k = 1; k <= 30; k++) begin @(posedge clk); #1 sample(k); end
    checks++;
    if (hc[0] + hc[1] + hc[2] + hc[3] !== 0) begin errors++; $display("FAIL mid_pulse_no_resume: high cycles=%0d expected 0", hc[0] + hc[1] + hc[2] + hc[3]); end
    run(5, 30);
    checks++;
    if (hc[0] !== 16 || fc[0] !== 4) begin errors++; $display("FAIL post_reset_accept: width=%0d first=%0d expected 16/4", hc[0], fc[0]); end
  endtask
  initial begin
    test_reset();
    test_cmd(1, 0, 1, 0, 0);
    test_cmd(0, 1, 0, 1, 3);
    test_cmd(1, 0, 0, 1, 1);
    test_cmd(0, 1, 1, 0, 2);
    test_invalid();
    test_held_request();
    test_back_to_back();
    test_reset_mid_pulse();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
